multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32 core. Accepts one instruction per handshake, latches it
//  in an internal IR, decodes opcode to drive the immediate extender (ImmSrc/en) and datapath
//  strobes, then steps FETCH->DECODE->EXEC->(MEM)->(WB). Waits on memory with a bounded timeout.
// PARAMETERS
//  DATA_WIDTH   32  instruction/IR width
//  MEM_TIMEOUT  15  max cycles in MEM with mem_ready low before abort; 0 = no timeout
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  en           in   1   advance enable; low = freeze state, all strobes 0
//  instr_valid  in   1   instruction available
//  instr_ready  out  1   controller accepts instruction (FETCH state only)
//  instr        in   32  instruction word
//  mem_ready    in   1   data memory access complete
//  alu_zero     in   1   ALU zero flag (branch compare)
//  ImmSrc       out  3   to extender: 000 I, 001 S, 010 B, 011 J, 100 U
//  imm_en       out  1   extender enable; 1 for every imm-bearing opcode in DECODE/EXEC/MEM/WB
//  alu_src_b    out  1   1 = immediate, 0 = rs2
//  result_src   out  2   00 ALU, 01 mem data, 10 PC+4, 11 immediate (LUI)
//  reg_write    out  1   register file write strobe
//  mem_read     out  1   load strobe
//  mem_write    out  1   store strobe
//  pc_write     out  1   PC update strobe, one cycle per retired instruction
//  pc_src       out  1   1 = branch/jump target, 0 = PC+4 (valid while pc_write)
//  mem_err      out  1   one-cycle pulse on memory timeout
//  illegal      out  1   unknown opcode (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state=FETCH, IR=0, counter=0, every output 0 incl. ImmSrc=000.
//  - Outputs registered/decoded from state+IR only; instr never reaches outputs combinationally.
//  - FETCH: instr_ready=en. instr_valid&&instr_ready -> IR<=instr, ->DECODE.
//  - DECODE: ImmSrc/imm_en/alu_src_b set from IR[6:0]; held until next FETCH. ->EXEC.
//    0000011 load I; 0010011 ALU-imm I; 1100111 JALR I; 0100011 store S; 1100011 branch B;
//    1101111 JAL J; 0110111 LUI U; 0010111 AUIPC U; 0110011 R-type imm_en=0, ImmSrc=000.
//  - EXEC: load/store ->MEM. branch: pc_write=1, pc_src=alu_zero^IR[12], ->FETCH.
//    all others ->WB.
//  - MEM: mem_read (load) or mem_write (store) held high; counter increments each cycle
//    mem_ready=0. mem_ready=1: load ->WB; store pc_write=1,pc_src=0, ->FETCH.
//    counter==MEM_TIMEOUT (nonzero) and mem_ready=0: mem_err=1, pc_write=1, pc_src=0, no
//    reg_write, ->FETCH. mem_ready and limit same cycle: mem_ready wins. Counter clears on exit.
//  - WB: reg_write=1, pc_write=1; result_src: load 01, JAL/JALR 10, LUI 11, else 00;
//    pc_src=1 for JAL/JALR. ->FETCH.
//  - Latency instr accept -> next instr_ready: ALU/LUI/JAL 4 cycles, branch 3, store 3+waits,
//    load 4+waits (+WB).
//  - en=0 any state: state/IR/counter hold; reg_write, mem_*, pc_write, instr_ready forced 0;
//    ImmSrc/imm_en hold. Timeout counter does not advance.
//  - rst mid-operation: immediate return to FETCH, in-flight strobes drop same instant.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode -> TRAP state after DECODE; illegal=1 held,
//   no strobes, instr_ready=0; exit only by rst.
//  ILLEGAL_TRAP_EN undefined: unknown opcode executes as NOP (EXEC: pc_write=1,pc_src=0,
//   ->FETCH); illegal tied 0.
// TESTING
//  - Reset: rst=1 mid-WB -> all outputs 0 same cycle; after release instr_ready=1 on first en cycle.
//  - ADDI 0x00500093: accepted, DECODE ImmSrc=000 imm_en=1 alu_src_b=1; WB reg_write=1
//    result_src=00 pc_write=1; instr_ready again 4 cycles after accept.
//  - SW 0x00112223 with mem_ready after 3 waits: ImmSrc=001, mem_write high 4 cycles,
//    pc_write=1 pc_src=0 on ready cycle, reg_write never 1.
//  - BEQ 0x00208463, alu_zero=1 -> ImmSrc=010, pc_write=1 pc_src=1; BNE same zero -> pc_src=0.
//  - LW with mem_ready stuck 0, MEM_TIMEOUT=15 -> mem_err pulse after 15 wait cycles, no
//    reg_write, back to FETCH; repeat with mem_ready=1 on limit cycle -> no mem_err, WB occurs.
//  - Opcode 0x7F: with ILLEGAL_TRAP_EN illegal=1 and instr_ready stays 0; without, NOP retire.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32 core.
// Steps FETCH -> DECODE -> EXEC -> (MEM) -> (WB), latching one instruction per
// handshake into an internal IR and decoding strobes from state + IR only.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode traps until reset;
// when undefined, an unknown opcode retires as a NOP and illegal stays 0).
module multicycle_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  mem_ready,
    input  logic                  alu_zero,
    output logic [2:0]            ImmSrc,
    output logic                  imm_en,
    output logic                  alu_src_b,
    output logic [1:0]            result_src,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  mem_err,
    output logic                  illegal
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic       op_load, op_store, op_branch, op_jal, op_jalr, op_lui, op_known;
    logic [2:0] dec_imm_src;
    logic       dec_imm_en, dec_alu_b;
    logic       timeout_hit;

    // Register and funct fields other than funct3[0] belong to the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_q[DATA_WIDTH-1:13], ir_q[11:7]};

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

    // State, instruction register and memory-wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Opcode decode of the latched instruction.
    always_comb begin
        op_load     = 1'b0;
        op_store    = 1'b0;
        op_branch   = 1'b0;
        op_jal      = 1'b0;
        op_jalr     = 1'b0;
        op_lui      = 1'b0;
        op_known    = 1'b1;
        dec_imm_src = 3'b000;
        dec_imm_en  = 1'b0;
        dec_alu_b   = 1'b0;
        case (ir_q[6:0])
            OP_LOAD:   begin op_load = 1'b1; dec_imm_en = 1'b1; dec_alu_b = 1'b1; end
            OP_ALUI:   begin dec_imm_en = 1'b1; dec_alu_b = 1'b1; end
            OP_JALR:   begin op_jalr = 1'b1; dec_imm_en = 1'b1; dec_alu_b = 1'b1; end
            OP_STORE:  begin op_store = 1'b1; dec_imm_src = 3'b001; dec_imm_en = 1'b1; dec_alu_b = 1'b1; end
            OP_BRANCH: begin op_branch = 1'b1; dec_imm_src = 3'b010; dec_imm_en = 1'b1; end
            OP_JAL:    begin op_jal = 1'b1; dec_imm_src = 3'b011; dec_imm_en = 1'b1; dec_alu_b = 1'b1; end
            OP_LUI:    begin op_lui = 1'b1; dec_imm_src = 3'b100; dec_imm_en = 1'b1; dec_alu_b = 1'b1; end
            OP_AUIPC:  begin dec_imm_src = 3'b100; dec_imm_en = 1'b1; dec_alu_b = 1'b1; end
            OP_RTYPE:  ;
            default:   op_known = 1'b0;
        endcase
    end

    // Next-state and output decode; en low freezes state and drops all strobes.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        ImmSrc      = 3'b000;
        imm_en      = 1'b0;
        alu_src_b   = 1'b0;
        result_src  = 2'b00;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        mem_err     = 1'b0;
        illegal     = (state_q == S_TRAP);

        if (state_q != S_FETCH && state_q != S_TRAP) begin
            ImmSrc    = dec_imm_src;
            imm_en    = dec_imm_en;
            alu_src_b = dec_alu_b;
        end

        if (state_q == S_WB) begin
            if (op_load)                result_src = 2'b01;
            else if (op_jal || op_jalr) result_src = 2'b10;
            else if (op_lui)            result_src = 2'b11;
        end

        // rst gating keeps instr_ready low while the flops are held in reset
        if (en && !rst) begin
            case (state_q)
                S_FETCH: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        ir_d    = instr;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
                    if (!op_known) state_d = S_TRAP;
`endif
                end
                S_EXEC: begin
                    if (op_load || op_store) begin
                        state_d = S_MEM;
                    end else if (op_branch) begin
                        pc_write = 1'b1;
                        pc_src   = alu_zero ^ ir_q[12];
                        state_d  = S_FETCH;
                    end else if (!op_known) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    mem_read  = op_load;
                    mem_write = op_store;
                    if (mem_ready) begin
                        cnt_d = '0;
                        if (op_load) begin
                            state_d = S_WB;
                        end else begin
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end else if (timeout_hit) begin
                        mem_err  = 1'b1;
                        pc_write = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_FETCH;
                    end else if (MEM_TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = op_jal || op_jalr;
                    state_d   = S_FETCH;
                end
                S_TRAP: ;
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Expected retire records are queued at issue and popped at retirement.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic [2:0]  ImmSrc;
    logic        imm_en;
    logic        alu_src_b;
    logic [1:0]  result_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic        pc_src;
    logic        mem_err;
    logic        illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       pc_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_err;
    } ret_t;

    typedef struct {
        logic       ready_at_issue;
        logic [2:0] imm_src;
        logic       imm_en;
        logic       alu_b;
        int         latency;
        int         mem_rd;
        int         mem_wr;
        int         reg_wr;
        int         retires;
        int         errs;
        logic       ret_pc_src;
        logic       ret_reg_write;
        logic [1:0] ret_result_src;
        logic       ret_mem_err;
        logic       saw_illegal;
    } obs_t;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  imm_src;
        logic        imm_en;
        logic        alu_b;
        logic [1:0]  rs;
        logic        pcs;
    } alu_vec_t;

    ret_t exp_q[$];

    multicycle_ctrl #(
        .DATA_WIDTH (32),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .ImmSrc     (ImmSrc),
        .imm_en     (imm_en),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .mem_err    (mem_err),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one instruction and run it to the next instr_ready (bounded).
    // waits = MEM cycles with mem_ready low before it is raised.
    task automatic exec_instr(input logic [31:0] ins, input int waits, input logic zero,
                              input int max_cyc, output obs_t o);
        int mem_idx;
        mem_idx = 0;
        o.ready_at_issue = 1'b0; o.imm_src = 3'b000; o.imm_en = 1'b0; o.alu_b = 1'b0;
        o.latency = 0; o.mem_rd = 0; o.mem_wr = 0; o.reg_wr = 0; o.retires = 0; o.errs = 0;
        o.ret_pc_src = 1'b0; o.ret_reg_write = 1'b0; o.ret_result_src = 2'b00;
        o.ret_mem_err = 1'b0; o.saw_illegal = 1'b0;
        @(negedge clk);
        en = 1'b1; instr = ins; instr_valid = 1'b1; alu_zero = zero; mem_ready = 1'b0;
        #1;
        o.ready_at_issue = instr_ready;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            instr_valid = 1'b0; instr = '1; mem_ready = 1'b0;
            #1;
            if (mem_read || mem_write) begin
                if (mem_idx == waits) begin
                    mem_ready = 1'b1;
                    #1;
                end
                mem_idx++;
            end
            if (c == 1) begin
                o.imm_src = ImmSrc; o.imm_en = imm_en; o.alu_b = alu_src_b;
            end
            if (instr_ready) begin
                o.latency = c;
                break;
            end
            if (illegal)   o.saw_illegal = 1'b1;
            if (mem_read)  o.mem_rd++;
            if (mem_write) o.mem_wr++;
            if (reg_write) o.reg_wr++;
            if (mem_err)   o.errs++;
            if (pc_write) begin
                o.retires++;
                o.ret_pc_src = pc_src; o.ret_reg_write = reg_write;
                o.ret_result_src = result_src; o.ret_mem_err = mem_err;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        rst = 1'b1; en = 1'b1; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0; alu_zero = 1'b0;
        @(negedge clk); #1;
        outs = {instr_ready, ImmSrc, imm_en, alu_src_b, result_src, reg_write, mem_read,
                mem_write, pc_write, pc_src, mem_err, illegal};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want %b", outs, 15'b0);
        end
        @(negedge clk); rst = 1'b0; #1;
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", instr_ready);
        end
        // walk an ADDI to WB, then reset in the middle of that cycle
        @(negedge clk); instr = 32'h00500093; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0; instr = '1;
        @(negedge clk);
        @(negedge clk); #1;
        tests_run++;
        if ({reg_write, pc_write} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_pre_wb: got %b want 11", {reg_write, pc_write});
        end
        #2 rst = 1'b1;
        #1;
        outs = {instr_ready, ImmSrc, imm_en, alu_src_b, result_src, reg_write, mem_read,
                mem_write, pc_write, pc_src, mem_err, illegal};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_wb: got %b want %b", outs, 15'b0);
        end
        @(negedge clk); rst = 1'b0; #1;
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_wb_release: got %b want 1", instr_ready);
        end
    endtask

    task automatic test_alu_class();
        alu_vec_t tbl[6];
        obs_t     o;
        ret_t     e;
        tbl[0] = '{32'h00500093, 3'b000, 1'b1, 1'b1, 2'b00, 1'b0};  // ADDI
        tbl[1] = '{32'h008000EF, 3'b011, 1'b1, 1'b1, 2'b10, 1'b1};  // JAL
        tbl[2] = '{32'h000080E7, 3'b000, 1'b1, 1'b1, 2'b10, 1'b1};  // JALR
        tbl[3] = '{32'h123450B7, 3'b100, 1'b1, 1'b1, 2'b11, 1'b0};  // LUI
        tbl[4] = '{32'h00001097, 3'b100, 1'b1, 1'b1, 2'b00, 1'b0};  // AUIPC
        tbl[5] = '{32'h002081B3, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0};  // ADD
        foreach (tbl[i]) begin
            exp_q.push_back('{tbl[i].pcs, 1'b1, tbl[i].rs, 1'b0});
            exec_instr(tbl[i].ins, 0, 1'b0, 40, o);
            e = exp_q.pop_front();
            tests_run++;
            if ({o.ready_at_issue, o.imm_src, o.imm_en, o.alu_b} !==
                {1'b1, tbl[i].imm_src, tbl[i].imm_en, tbl[i].alu_b}) begin
                tests_failed++;
                $display("FAIL alu[%0d]_decode: got %b want %b", i,
                         {o.ready_at_issue, o.imm_src, o.imm_en, o.alu_b},
                         {1'b1, tbl[i].imm_src, tbl[i].imm_en, tbl[i].alu_b});
            end
            tests_run++;
            if ({o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err} !==
                {e.pc_src, e.reg_write, e.result_src, e.mem_err} || o.retires != 1) begin
                tests_failed++;
                $display("FAIL alu[%0d]_retire: got %b x%0d want %b x1", i,
                         {o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err},
                         o.retires, {e.pc_src, e.reg_write, e.result_src, e.mem_err});
            end
            tests_run++;
            if (o.latency != 4) begin
                tests_failed++;
                $display("FAIL alu[%0d]_latency: got %0d want 4", i, o.latency);
            end
        end
    endtask

    task automatic test_store();
        obs_t o;
        ret_t e;
        exp_q.push_back('{1'b0, 1'b0, 2'b00, 1'b0});
        exec_instr(32'h00112223, 3, 1'b0, 40, o);
        e = exp_q.pop_front();
        tests_run++;
        if ({o.imm_src, o.imm_en, o.alu_b} !== 5'b001_1_1) begin
            tests_failed++;
            $display("FAIL sw_decode: got %b want 00111", {o.imm_src, o.imm_en, o.alu_b});
        end
        tests_run++;
        if (o.mem_wr != 4 || o.mem_rd != 0 || o.reg_wr != 0) begin
            tests_failed++;
            $display("FAIL sw_strobes: got wr=%0d rd=%0d rw=%0d want wr=4 rd=0 rw=0",
                     o.mem_wr, o.mem_rd, o.reg_wr);
        end
        tests_run++;
        if ({o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err} !==
            {e.pc_src, e.reg_write, e.result_src, e.mem_err} || o.retires != 1) begin
            tests_failed++;
            $display("FAIL sw_retire: got %b x%0d want %b x1",
                     {o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err},
                     o.retires, {e.pc_src, e.reg_write, e.result_src, e.mem_err});
        end
        tests_run++;
        if (o.latency != 7) begin
            tests_failed++;
            $display("FAIL sw_latency: got %0d want 7", o.latency);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins  [3];
        logic        zero [3];
        logic        pcs  [3];
        obs_t        o;
        ret_t        e;
        ins[0] = 32'h00208463; zero[0] = 1'b1; pcs[0] = 1'b1;  // BEQ taken
        ins[1] = 32'h00209463; zero[1] = 1'b1; pcs[1] = 1'b0;  // BNE not taken
        ins[2] = 32'h00208463; zero[2] = 1'b0; pcs[2] = 1'b0;  // BEQ not taken
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{pcs[i], 1'b0, 2'b00, 1'b0});
            exec_instr(ins[i], 0, zero[i], 40, o);
            e = exp_q.pop_front();
            tests_run++;
            if ({o.imm_src, o.imm_en, o.alu_b} !== 5'b010_1_0) begin
                tests_failed++;
                $display("FAIL br[%0d]_decode: got %b want 01010", i,
                         {o.imm_src, o.imm_en, o.alu_b});
            end
            tests_run++;
            if ({o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err} !==
                {e.pc_src, e.reg_write, e.result_src, e.mem_err} || o.retires != 1
                || o.latency != 3) begin
                tests_failed++;
                $display("FAIL br[%0d]_retire: got %b x%0d lat=%0d want %b x1 lat=3", i,
                         {o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err},
                         o.retires, o.latency, {e.pc_src, e.reg_write, e.result_src, e.mem_err});
            end
        end
    endtask

    task automatic test_load_timeout();
        obs_t o;
        ret_t e;
        // mem_ready never arrives
        exp_q.push_back('{1'b0, 1'b0, 2'b00, 1'b1});
        exec_instr(32'h0000A103, 1000, 1'b0, 60, o);
        e = exp_q.pop_front();
        tests_run++;
        if ({o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err} !==
            {e.pc_src, e.reg_write, e.result_src, e.mem_err} || o.errs != 1 || o.reg_wr != 0) begin
            tests_failed++;
            $display("FAIL lw_timeout_retire: got %b errs=%0d rw=%0d want %b errs=1 rw=0",
                     {o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err},
                     o.errs, o.reg_wr, {e.pc_src, e.reg_write, e.result_src, e.mem_err});
        end
        tests_run++;
        if (o.mem_rd != 16 || o.latency != 19) begin
            tests_failed++;
            $display("FAIL lw_timeout_len: got rd=%0d lat=%0d want rd=16 lat=19",
                     o.mem_rd, o.latency);
        end
        // mem_ready arrives on the limit cycle
        exp_q.push_back('{1'b0, 1'b1, 2'b01, 1'b0});
        exec_instr(32'h0000A103, 15, 1'b0, 60, o);
        e = exp_q.pop_front();
        tests_run++;
        if ({o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err} !==
            {e.pc_src, e.reg_write, e.result_src, e.mem_err} || o.errs != 0 || o.retires != 1) begin
            tests_failed++;
            $display("FAIL lw_limit_retire: got %b errs=%0d x%0d want %b errs=0 x1",
                     {o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err},
                     o.errs, o.retires, {e.pc_src, e.reg_write, e.result_src, e.mem_err});
        end
        tests_run++;
        if (o.mem_rd != 16 || o.latency != 20 || o.imm_src !== 3'b000 || o.imm_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_limit_len: got rd=%0d lat=%0d imm=%b/%b want rd=16 lat=20 imm=000/1",
                     o.mem_rd, o.latency, o.imm_src, o.imm_en);
        end
    endtask

    task automatic test_enable();
        int en_mem;
        bit leak;
        bit got_err;
        @(negedge clk); en = 1'b1; instr = 32'h00500093; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0; instr = '1; en = 1'b0; #1;
        tests_run++;
        if ({instr_ready, ImmSrc, imm_en, alu_src_b} !== 6'b0_000_11) begin
            tests_failed++;
            $display("FAIL en_hold_decode: got %b want 000011",
                     {instr_ready, ImmSrc, imm_en, alu_src_b});
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        @(negedge clk); en = 1'b0; #1;
        tests_run++;
        if ({reg_write, pc_write} !== 2'b00) begin
            tests_failed++;
            $display("FAIL en_gate_wb: got %b want 00", {reg_write, pc_write});
        end
        @(negedge clk); en = 1'b1; #1;
        tests_run++;
        if ({reg_write, pc_write} !== 2'b11) begin
            tests_failed++;
            $display("FAIL en_resume_wb: got %b want 11", {reg_write, pc_write});
        end
        // load stalls in MEM; en low for 5 cycles must not advance the timeout
        @(negedge clk); instr = 32'h0000A103; instr_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk); instr_valid = 1'b0; instr = '1;
        @(negedge clk);
        en_mem = 0; leak = 1'b0; got_err = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            en = !(k >= 5 && k < 10);
            #1;
            if (!en && (mem_read || pc_write || mem_err)) leak = 1'b1;
            if (en && mem_read) en_mem++;
            if (mem_err) begin
                got_err = 1'b1;
                break;
            end
        end
        en = 1'b1;
        tests_run++;
        if (!got_err || en_mem != 16 || leak) begin
            tests_failed++;
            $display("FAIL en_freeze_timeout: got err=%0d cycles=%0d leak=%0d want err=1 cycles=16 leak=0",
                     got_err, en_mem, leak);
        end
        @(negedge clk); #1;
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL en_timeout_fetch: got %b want 1", instr_ready);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
`ifdef ILLEGAL_TRAP_EN
        exec_instr(32'h0000007F, 0, 1'b0, 10, o);
        tests_run++;
        if (!o.saw_illegal || o.latency != 0 || o.retires != 0) begin
            tests_failed++;
            $display("FAIL illegal_trap: got ill=%0d lat=%0d ret=%0d want ill=1 lat=0 ret=0",
                     o.saw_illegal, o.latency, o.retires);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        tests_run++;
        if ({illegal, instr_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL illegal_reset_exit: got %b want 01", {illegal, instr_ready});
        end
`else
        ret_t e;
        exp_q.push_back('{1'b0, 1'b0, 2'b00, 1'b0});
        exec_instr(32'h0000007F, 0, 1'b0, 20, o);
        e = exp_q.pop_front();
        tests_run++;
        if ({o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err} !==
            {e.pc_src, e.reg_write, e.result_src, e.mem_err} || o.retires != 1
            || o.latency != 3 || o.saw_illegal) begin
            tests_failed++;
            $display("FAIL illegal_nop: got %b x%0d lat=%0d ill=%0d want %b x1 lat=3 ill=0",
                     {o.ret_pc_src, o.ret_reg_write, o.ret_result_src, o.ret_mem_err},
                     o.retires, o.latency, o.saw_illegal,
                     {e.pc_src, e.reg_write, e.result_src, e.mem_err});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_class();
        test_store();
        test_branch();
        test_load_timeout();
        test_enable();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
